seven_segment_value_decoder: RTL

SEVEN_SEGMENT_VALUE_DECODER -- requirements
Module: seven_segment_value_decoder

---
 rtl/seven_segment_value_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seven_segment_value_decoder.sv
// seven_segment_value_decoder
// Accepts a 14-bit binary value and converts it to four BCD digits with a
// serial shift-and-add-3 engine. It saturates values above 9999. It drives
// the digit picked by a one-hot digit_select onto active-low segment lines.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading
// zero digits. The ones digit always shows.
module seven_segment_value_decoder (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [13:0] value,
   input  logic [3:0]  dp_sel,
   input  logic        value_valid,
   output logic        ready,
   input  logic [3:0]  digit_select,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        over_range
);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [13:0] r_bin;
   logic [15:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_ovr;
   logic [3:0]  r_dp_cap;
   logic [15:0] r_disp;
   logic [3:0]  r_dp;

   logic        w_xfer;
   logic        w_commit;
   logic [15:0] w_bcd_adj;
   logic [15:0] w_disp_nxt;
   logic [3:0]  w_dp_nxt;
   logic [3:0]  w_digit;
   logic        w_dp_bit;
   logic        w_sel_ok;
   logic        w_blank;

   // Map a BCD digit to its active-low {g,f,e,d,c,b,a} pattern.
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = 7'b1111111;
      endcase
   endfunction

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state and ready. CONVERT holds for 14 shifts (r_cnt 0..13).
   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (value_valid) w_state_nxt = S_CONVERT;
         end
         S_CONVERT: if (r_cnt == 4'd13) w_state_nxt = S_COMMIT;
         S_COMMIT:  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   assign w_xfer   = value_valid & ready;
   assign w_commit = (r_state == S_COMMIT);

   // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 4; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end

   // Conversion datapath: capture on transfer, then shift one bit per cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_ovr    <= 1'b0;
         r_dp_cap <= '0;
      end else if (w_xfer) begin
         r_bin    <= value;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_ovr    <= (value > 14'd9999);
         r_dp_cap <= dp_sel;
      end else if (r_state == S_CONVERT) begin
         r_bcd <= (w_bcd_adj << 1) | {15'd0, r_bin[13]};
         r_bin <= r_bin << 1;
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // Next display contents. Only COMMIT changes them; the >9999 case saturates.
   assign w_disp_nxt = w_commit ? (r_ovr ? 16'h9999 : r_bcd) : r_disp;
   assign w_dp_nxt   = w_commit ? r_dp_cap : r_dp;

   // Display register and over_range update together at commit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_disp     <= '0;
         r_dp       <= '0;
         over_range <= 1'b0;
      end else if (w_commit) begin
         r_disp     <= w_disp_nxt;
         r_dp       <= w_dp_nxt;
         over_range <= r_ovr;
      end
   end

   // Digit mux. It reads the next display value, so a digit_select change
   // that lands on the commit edge already shows the new value.
   always_comb begin
      w_digit  = 4'd0;
      w_dp_bit = 1'b0;
      w_sel_ok = 1'b1;
      case (digit_select)
         4'b1000: begin w_digit = w_disp_nxt[15:12]; w_dp_bit = w_dp_nxt[3]; end
         4'b0100: begin w_digit = w_disp_nxt[11:8];  w_dp_bit = w_dp_nxt[2]; end
         4'b0010: begin w_digit = w_disp_nxt[7:4];   w_dp_bit = w_dp_nxt[1]; end
         4'b0001: begin w_digit = w_disp_nxt[3:0];   w_dp_bit = w_dp_nxt[0]; end
         default: w_sel_ok = 1'b0;
      endcase
   end

   // Leading-zero blanking: a digit is blank when it and every higher digit are 0.
   always_comb begin
      w_blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      case (digit_select)
         4'b1000: w_blank = (w_disp_nxt[15:12] == 4'd0);
         4'b0100: w_blank = (w_disp_nxt[15:8]  == 8'd0);
         4'b0010: w_blank = (w_disp_nxt[15:4]  == 12'd0);
         default: w_blank = 1'b0;
      endcase
`endif
   end

   // Registered cathode drive. Blanking does not touch dp_n.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg_n <= 7'b1111111;
         dp_n  <= 1'b1;
      end else begin
         seg_n <= (!w_sel_ok || w_blank) ? 7'b1111111 : f_seg(w_digit);
         dp_n  <= ~(w_sel_ok & w_dp_bit);
      end
   end

endmodule
